// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR addresses, mstatus bit
// positions, set/clear/write mode encodings and WARL masks.
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int IRQ_BASE       = 16;

  typedef enum logic [1:0] {
    WSC_WRITE0 = 2'b00,
    WSC_WRITE  = 2'b01,
    WSC_SET    = 2'b10,
    WSC_CLEAR  = 2'b11
  } wsc_mode_e;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/csr_unit_m_if.sv
// CSR access bus between the EX/WB stage (master) and the CSR unit (slave).
interface csr_unit_m_if #(
  parameter int XLEN = 32
);
  logic [11:0]     csr_rd_addr;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            csr_we;
  logic [11:0]     csr_wr_addr;
  logic [1:0]      csr_wsc_mode;
  logic [XLEN-1:0] csr_wdata;

  modport master (
    output csr_rd_addr, csr_we, csr_wr_addr, csr_wsc_mode, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_rd_addr, csr_we, csr_wr_addr, csr_wsc_mode, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves;
// a half write replaces that half and suppresses the increment for the cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[63:32] <= wdata;
    end else if (en) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_unit_m.sv
// Machine-mode CSR unit: RW/RS/RC access, trap entry/mret, interrupt pending/cause
// and trap vector. Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module csr_unit_m
  import csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              NUM_IRQ   = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic               clk,
  input  logic               rst,
  csr_unit_m_if.slave        bus,
  input  logic               is_trap,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic [XLEN-1:0]    trap_cause,
  input  logic [XLEN-1:0]    trap_val,
  input  logic               is_mret,
  input  logic               instr_retire,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_pending,
  output logic [XLEN-1:0]    irq_cause,
  output logic [XLEN-1:0]    trap_target,
  output logic [XLEN-1:0]    mepc_o,
  output logic [XLEN-1:0]    mstatus_o
);

  localparam logic [XLEN-1:0] IRQ_MASK =
    XLEN'(((64'd1 << NUM_IRQ) - 64'd1) << IRQ_BASE);
  localparam logic [XLEN-1:0] MTVEC_WMASK = XLEN'(MTVEC_MASK);
  localparam logic [XLEN-1:0] MEPC_WMASK  = XLEN'(MEPC_MASK);

  logic            mie_bit, mpie_bit;
  logic [XLEN-1:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r, mip_r;
  logic [XLEN-1:0] mstatus_val, irq_vec, irq_active, wr_val;
  logic [XLEN:0]   rd_look, wr_look;
  logic            wr_en;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
`endif

  function automatic logic [XLEN-1:0] apply_wsc(input logic [1:0] mode,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] operand);
    case (mode)
      WSC_SET:   return old_val | operand;
      WSC_CLEAR: return old_val & ~operand;
      default:   return operand;
    endcase
  endfunction

  // Returns {implemented, value} for a CSR address from current state.
  function automatic logic [XLEN:0] csr_lookup(input logic [11:0] addr);
    logic [XLEN:0] r;
    r = '0;
    r[XLEN] = 1'b1;
    case (addr)
      ADDR_MSTATUS:   r[XLEN-1:0] = mstatus_val;
      ADDR_MISA:      r[XLEN-1:0] = XLEN'(MISA_VALUE);
      ADDR_MIE:       r[XLEN-1:0] = mie_r;
      ADDR_MTVEC:     r[XLEN-1:0] = mtvec_r;
      ADDR_MSCRATCH:  r[XLEN-1:0] = mscratch_r;
      ADDR_MEPC:      r[XLEN-1:0] = mepc_r;
      ADDR_MCAUSE:    r[XLEN-1:0] = mcause_r;
      ADDR_MTVAL:     r[XLEN-1:0] = mtval_r;
      ADDR_MIP:       r[XLEN-1:0] = mip_r;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:    r[XLEN-1:0] = XLEN'(mcycle[31:0]);
      ADDR_MCYCLEH:   r[XLEN-1:0] = XLEN'(mcycle[63:32]);
      ADDR_MINSTRET:  r[XLEN-1:0] = XLEN'(minstret[31:0]);
      ADDR_MINSTRETH: r[XLEN-1:0] = XLEN'(minstret[63:32]);
`endif
      default:        r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE]  = mie_bit;
    mstatus_val[MSTATUS_MPIE] = mpie_bit;
    mstatus_val[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    rd_look         = csr_lookup(bus.csr_rd_addr);
    bus.csr_rdata   = rd_look[XLEN-1:0];
    bus.csr_illegal = ~rd_look[XLEN];
  end

  // A trap or mret in the same cycle cancels the software write entirely.
  always_comb begin
    wr_look = csr_lookup(bus.csr_wr_addr);
    wr_val  = apply_wsc(bus.csr_wsc_mode, wr_look[XLEN-1:0], bus.csr_wdata);
    wr_en   = bus.csr_we & ~is_trap & ~is_mret & wr_look[XLEN];
  end

  assign irq_vec    = XLEN'(irq_in) << IRQ_BASE;
  assign irq_active = mip_r & mie_r;
  assign irq_pending = mie_bit & (|irq_active);

  always_comb begin
    irq_cause = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_active[IRQ_BASE+i]) irq_cause = {1'b1, (XLEN-1)'(IRQ_BASE + i)};
    end
  end

  always_comb begin
    trap_target = {mtvec_r[XLEN-1:2], 2'b00};
    if (mtvec_r[0] && trap_cause[XLEN-1])
      trap_target = {mtvec_r[XLEN-1:2], 2'b00} + XLEN'({trap_cause[4:0], 2'b00});
  end

  assign mepc_o    = mepc_r;
  assign mstatus_o = mstatus_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_bit    <= 1'b1;
      mpie_bit   <= 1'b1;
      mie_r      <= '0;
      mtvec_r    <= RESET_VEC;
      mscratch_r <= '0;
      mepc_r     <= '0;
      mcause_r   <= '0;
      mtval_r    <= '0;
      mip_r      <= '0;
    end else begin
      mip_r <= irq_vec;
      if (is_trap) begin
        mepc_r   <= trap_pc & MEPC_WMASK;
        mcause_r <= trap_cause;
        mtval_r  <= trap_val;
        mpie_bit <= mie_bit;
        mie_bit  <= 1'b0;
      end else if (is_mret) begin
        mie_bit  <= mpie_bit;
        mpie_bit <= 1'b1;
      end else if (wr_en) begin
        case (bus.csr_wr_addr)
          ADDR_MSTATUS: begin
            mie_bit  <= wr_val[MSTATUS_MIE];
            mpie_bit <= wr_val[MSTATUS_MPIE];
          end
          ADDR_MIE:      mie_r      <= wr_val & IRQ_MASK;
          ADDR_MTVEC:    mtvec_r    <= wr_val & MTVEC_WMASK;
          ADDR_MSCRATCH: mscratch_r <= wr_val;
          ADDR_MEPC:     mepc_r     <= wr_val & MEPC_WMASK;
          ADDR_MCAUSE:   mcause_r   <= wr_val;
          ADDR_MTVAL:    mtval_r    <= wr_val;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .wr_lo (wr_en && bus.csr_wr_addr == ADDR_MCYCLE),
    .wr_hi (wr_en && bus.csr_wr_addr == ADDR_MCYCLEH),
    .wdata (wr_val[31:0]),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .en    (instr_retire),
    .wr_lo (wr_en && bus.csr_wr_addr == ADDR_MINSTRET),
    .wr_hi (wr_en && bus.csr_wr_addr == ADDR_MINSTRETH),
    .wdata (wr_val[31:0]),
    .value (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

endmodule

// File: tb/tb_csr_unit_m.sv
// Scoreboard bench for csr_unit_m: directed scenarios then randomized traffic,
// all checked against a CSR-map reference model kept as an address-indexed array.
module tb_csr_unit_m;
  localparam int          XLEN      = 32;
  localparam int          NUM_IRQ   = 4;
  localparam logic [31:0] RESET_VEC = 32'h0000_0100;

  typedef struct {
    bit        rst_n;
    bit [11:0] rd_addr;
    bit        we;
    bit [11:0] wr_addr;
    bit [1:0]  mode;
    bit [31:0] wdata;
    bit        trap;
    bit [31:0] pc, cause, tval;
    bit        mret;
    bit        retire;
    bit [3:0]  irq;
  } stim_t;

  typedef struct {
    bit [31:0] rdata;
    bit        ill;
    bit        pend;
    bit [31:0] icause, target, mepc, mstatus;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_trap, is_mret, instr_retire, irq_pending;
  logic [31:0] trap_pc, trap_cause, trap_val, irq_cause, trap_target, mepc_o, mstatus_o;
  logic [3:0]  irq_in;

  csr_unit_m_if #(.XLEN(XLEN)) bus ();

  csr_unit_m #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .RESET_VEC(RESET_VEC)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .is_trap(is_trap), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_val(trap_val),
    .is_mret(is_mret), .instr_retire(instr_retire), .irq_in(irq_in),
    .irq_pending(irq_pending), .irq_cause(irq_cause), .trap_target(trap_target),
    .mepc_o(mepc_o), .mstatus_o(mstatus_o)
  );

  always #5 clk = ~clk;

  bit [31:0] m [int];
  bit [63:0] mcyc, minst;
  exp_t      sb [$];
  stim_t     cur;
  int        n_cmp = 0;
  int        n_fail = 0;

  function automatic void model_reset();
    m.delete();
    m['h300] = 32'h0000_1888;
    m['h301] = 32'h4000_0100;
    m['h304] = 32'h0;
    m['h305] = RESET_VEC;
    for (int a = 'h340; a <= 'h344; a++) m[a] = 32'h0;
    mcyc  = 64'h0;
    minst = 64'h0;
  endfunction

  function automatic bit is_counter(int a);
`ifdef CSR_COUNTERS_EN
    return a == 'hB00 || a == 'hB80 || a == 'hB02 || a == 'hB82;
`else
    return a < 0;
`endif
  endfunction

  function automatic bit [31:0] model_read(int a);
    case (a)
      'hB00:   return is_counter(a) ? mcyc[31:0]   : 32'h0;
      'hB80:   return is_counter(a) ? mcyc[63:32]  : 32'h0;
      'hB02:   return is_counter(a) ? minst[31:0]  : 32'h0;
      'hB82:   return is_counter(a) ? minst[63:32] : 32'h0;
      default: return m.exists(a) ? m[a] : 32'h0;
    endcase
  endfunction

  // Bits software may change; zero means read-only or unimplemented.
  function automatic bit [31:0] wmask(int a);
    case (a)
      'h300:               return 32'h0000_0088;
      'h304:               return 32'h000F_0000;
      'h305:               return 32'hFFFF_FFFD;
      'h340, 'h342, 'h343: return 32'hFFFF_FFFF;
      'h341:               return 32'hFFFF_FFFC;
      default:             return 32'h0;
    endcase
  endfunction

  function automatic exp_t model_out(stim_t s);
    exp_t      e;
    bit [31:0] act, st, tv;
    act = m['h344] & m['h304];
    st  = m['h300];
    tv  = m['h305];
    e.rdata  = model_read(int'(s.rd_addr));
    e.ill    = !(m.exists(int'(s.rd_addr)) || is_counter(int'(s.rd_addr)));
    e.pend   = st[3] && act != 0;
    e.icause = 32'h0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (act[16+i] && e.icause == 0) e.icause = 32'h8000_0000 | 32'(16 + i);
    e.target = tv & ~32'h3;
    if (tv[0] && s.cause[31]) e.target = e.target + {25'b0, s.cause[4:0], 2'b00};
    e.mepc    = m['h341];
    e.mstatus = st;
    return e;
  endfunction

  function automatic void model_update(stim_t s);
    int        a;
    bit [31:0] nv, st, old;
    bit        cw, iw;
    a  = int'(s.wr_addr);
    st = m['h300];
    cw = 1'b0;
    iw = 1'b0;
    if (s.trap) begin
      m['h300] = 32'h1800 | (st[3] ? 32'h80 : 32'h0);
      m['h341] = s.pc & ~32'h3;
      m['h342] = s.cause;
      m['h343] = s.tval;
    end else if (s.mret) begin
      m['h300] = 32'h1880 | (st[7] ? 32'h8 : 32'h0);
    end else if (s.we) begin
      old = model_read(a);
      case (s.mode)
        2'b10:   nv = old | s.wdata;
        2'b11:   nv = old & ~s.wdata;
        default: nv = s.wdata;
      endcase
      if (m.exists(a)) m[a] = (m[a] & ~wmask(a)) | (nv & wmask(a));
      else if (is_counter(a)) begin
        case (a)
          'hB00:   begin mcyc[31:0]   = nv; cw = 1'b1; end
          'hB80:   begin mcyc[63:32]  = nv; cw = 1'b1; end
          'hB02:   begin minst[31:0]  = nv; iw = 1'b1; end
          default: begin minst[63:32] = nv; iw = 1'b1; end
        endcase
      end
    end
    if (!cw) mcyc = mcyc + 64'd1;
    if (!iw && s.retire) minst = minst + 64'd1;
    m['h344] = {12'b0, s.irq, 16'b0};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.rst_n   = 1'b1;
    s.rd_addr = 12'h300;
    return s;
  endfunction

  task automatic set_sigs(input stim_t s);
    rst              = s.rst_n;
    bus.csr_rd_addr  = s.rd_addr;
    bus.csr_we       = s.we;
    bus.csr_wr_addr  = s.wr_addr;
    bus.csr_wsc_mode = s.mode;
    bus.csr_wdata    = s.wdata;
    is_trap          = s.trap;
    trap_pc          = s.pc;
    trap_cause       = s.cause;
    trap_val         = s.tval;
    is_mret          = s.mret;
    instr_retire     = s.retire;
    irq_in           = s.irq;
  endtask

  task automatic drive_cycle(input stim_t s);
    set_sigs(s);
    if (!s.rst_n) model_reset();
    cur = s;
    sb.push_back(model_out(s));
    #1;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    if (rst) model_update(cur);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_rdata",   bus.csr_rdata,            e.rdata);
        chk("sb_illegal", 32'(bus.csr_illegal),     32'(e.ill));
        chk("sb_pending", 32'(irq_pending),         32'(e.pend));
        chk("sb_cause",   irq_cause,                e.icause);
        chk("sb_target",  trap_target,              e.target);
        chk("sb_mepc",    mepc_o,                   e.mepc);
        chk("sb_mstatus", mstatus_o,                e.mstatus);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t     s;
    bit [11:0] pool [16];
    pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
             12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'h000, 12'hF11};
    s = idle();
    s.rst_n = 1'b0;
    set_sigs(s);
    model_reset();
    @(posedge clk);
    #1;

    // Reset values
    drive_cycle(s);
    chk("rst_mstatus", mstatus_o, 32'h0000_1888);
    chk("rst_mepc", mepc_o, 32'h0);
    finish_cycle();
    s = idle(); s.rd_addr = 12'h305; drive_cycle(s);
    chk("rst_mtvec", bus.csr_rdata, RESET_VEC);
    finish_cycle();
    s.rd_addr = 12'h7C0; drive_cycle(s);
    chk("unimpl_rdata", bus.csr_rdata, 32'h0);
    chk("unimpl_illegal", 32'(bus.csr_illegal), 32'h1);
    finish_cycle();

    // Write / set / clear on mscratch, then read-only mip
    s = idle(); s.we = 1'b1; s.wr_addr = 12'h340; s.mode = 2'b01; s.wdata = 32'hF0;
    drive_cycle(s); finish_cycle();
    s.mode = 2'b10; s.wdata = 32'h0F; drive_cycle(s); finish_cycle();
    s.mode = 2'b11; s.wdata = 32'h30; drive_cycle(s); finish_cycle();
    s = idle(); s.rd_addr = 12'h340; drive_cycle(s);
    chk("rs_rc_mscratch", bus.csr_rdata, 32'h0000_00CF);
    finish_cycle();
    s = idle(); s.irq = 4'b0101; drive_cycle(s); finish_cycle();
    s.we = 1'b1; s.wr_addr = 12'h344; s.mode = 2'b01; s.wdata = 32'h0; drive_cycle(s); finish_cycle();
    s.we = 1'b0; s.rd_addr = 12'h344; drive_cycle(s);
    chk("mip_readonly", bus.csr_rdata, 32'h0005_0000);
    finish_cycle();

    // Trap entry then mret
    s = idle(); s.trap = 1'b1; s.pc = 32'h1003; s.cause = 32'h2; drive_cycle(s); finish_cycle();
    chk("trap_mepc", mepc_o, 32'h1000);
    chk("trap_mstatus", mstatus_o, 32'h0000_1880);
    s = idle(); s.mret = 1'b1; s.rd_addr = 12'h342; drive_cycle(s);
    chk("trap_mcause", bus.csr_rdata, 32'h2);
    finish_cycle();
    chk("mret_mstatus", mstatus_o, 32'h0000_1888);

    // Trap beats a same-cycle write
    s = idle(); s.trap = 1'b1; s.pc = 32'h2000; s.cause = 32'h5;
    s.we = 1'b1; s.wr_addr = 12'h341; s.mode = 2'b01; s.wdata = 32'h3333;
    drive_cycle(s); finish_cycle();
    chk("collide_mepc", mepc_o, 32'h2000);
    s = idle(); s.we = 1'b1; s.wr_addr = 12'h341; s.mode = 2'b01; s.wdata = 32'h4447;
    drive_cycle(s); finish_cycle();
    chk("write_mepc", mepc_o, 32'h4444);
    s = idle(); s.mret = 1'b1; drive_cycle(s); finish_cycle();

    // Vectored interrupt
    s = idle(); s.we = 1'b1; s.mode = 2'b01; s.wr_addr = 12'h305; s.wdata = 32'h201;
    drive_cycle(s); finish_cycle();
    s.wr_addr = 12'h304; s.wdata = 32'h0002_0000; drive_cycle(s); finish_cycle();
    s = idle(); s.irq = 4'b0010; drive_cycle(s);
    chk("irq_latency", 32'(irq_pending), 32'h0);
    finish_cycle();
    s.cause = 32'h8000_0011; drive_cycle(s);
    chk("irq_pending", 32'(irq_pending), 32'h1);
    chk("irq_cause", irq_cause, 32'h8000_0011);
    chk("irq_target", trap_target, 32'h0000_0244);
    finish_cycle();

`ifdef CSR_COUNTERS_EN
    s = idle(); s.we = 1'b1; s.mode = 2'b01; s.wr_addr = 12'hB00; s.wdata = 32'hFFFF_FFFF;
    drive_cycle(s); finish_cycle();
    s.wr_addr = 12'hB80; drive_cycle(s); finish_cycle();
    s = idle(); s.rd_addr = 12'hB00; drive_cycle(s);
    chk("mcycle_full", bus.csr_rdata, 32'hFFFF_FFFF);
    finish_cycle();
    s.rd_addr = 12'hB80; drive_cycle(s);
    chk("mcycle_wrap_hi", bus.csr_rdata, 32'h0);
    finish_cycle();
    s.rd_addr = 12'hB00; drive_cycle(s);
    chk("mcycle_after_wrap", bus.csr_rdata, 32'h1);
    finish_cycle();
`endif

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 2000; i++) begin
      s = idle();
      if (i % 700 == 350 || i % 700 == 351) s.rst_n = 1'b0;
      s.rd_addr = pool[$urandom_range(0, 15)];
      s.we      = 1'($urandom_range(0, 1));
      s.wr_addr = pool[$urandom_range(0, 15)];
      s.mode    = 2'($urandom);
      s.wdata   = $urandom;
      s.trap    = ($urandom_range(0, 7) == 0);
      s.pc      = $urandom;
      s.cause   = $urandom;
      if ($urandom_range(0, 1) == 1) s.cause = s.cause & 32'h8000_001F;
      s.tval    = $urandom;
      s.mret    = ($urandom_range(0, 7) == 0);
      s.retire  = 1'($urandom_range(0, 1));
      s.irq     = 4'($urandom);
      drive_cycle(s);
      finish_cycle();
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
